// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding bus master front end for a CPU memory stage.
// A request is latched in IDLE, presented on the bus for as long as BUSY lasts,
// and completed with a one-cycle DONE pulse.
// Optional build macro: BUS_TIMEOUT_EN. When it is defined, a BUSY phase that
// sees no bus_ack_i for TIMEOUT_CYCLES cycles is aborted, and cpu_err_o pulses.
module bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic        bus_we_o,
  output logic [15:0] bus_select_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        busy;

`ifdef BUS_TIMEOUT_EN
  // The counter value that, once reached without an ack, triggers the abort.
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  // The timeout length has no meaning when the abort logic is not built.
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
`endif

  // Next-state logic: latch the request, wait for ack (or a timeout), pulse done.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          we_d    = cpu_we_i;
          state_d = BUSY;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      BUSY: begin
        // An ack wins over a timeout that expires in the same cycle.
        if (bus_ack_i) begin
          if (!we_q) begin
            rdata_d = bus_data_i;
          end
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          cnt_d   = cnt_q + 8'd1;
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        // Completion is a single cycle; a request held high waits for IDLE.
        state_d = IDLE;
`ifdef BUS_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Timeout counter and abort flag, observed only while in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cpu_err_o = (state_q == DONE) && err_q;
`else
  assign cpu_err_o = 1'b0;
`endif

  // Bus side is driven only during BUSY, straight from the latched request,
  // so it cannot move while the transaction is in flight.
  assign busy         = (state_q == BUSY);
  assign bus_addr_o   = busy ? addr_q : 32'd0;
  assign bus_we_o     = busy && we_q;
  assign bus_data_o   = (busy && we_q) ? wdata_q : 32'd0;
  assign bus_select_o = busy ? (16'h0001 << addr_q[31:28]) : 16'h0000;

  // CPU side: stall is masked during reset so the pipeline is never frozen by it.
  assign cpu_stall_o  = !rst_i && (((state_q == IDLE) && cpu_req_i) || busy);
  assign cpu_done_o   = (state_q == DONE);
  assign cpu_data_o   = rdata_q;

endmodule
